// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg
// Shared definitions for the edge-triggered request arbiter: default
// geometry (number of request lines, grant index width) and the FSM
// state encoding used by edge_req_arbiter.
package edge_arb_pkg;

  localparam int N_DEF   = 4;
  localparam int IDW_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/edge_capture_cell.sv
// edge_capture_cell
// One request line: synchronises the raw level, detects its rising edge,
// and keeps the pending and sticky overrun flags for that line.
// All state updates on the falling edge of the clock.
//
// Ports
//   i_clk       clock (state updates on negedge)
//   i_rst_n     asynchronous active-low reset
//   i_raw       raw request level, asynchronous to i_clk
//   i_en        line enable; strobes are dropped while low
//   i_clr_pend  arbiter consumed this line's grant this cycle
//   i_clr_ovr   write-one-to-clear for the overrun flag
//   o_pend      pending request
//   o_ovr       sticky overrun flag
module edge_capture_cell
  import edge_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_en,
  input  logic i_clr_pend,
  input  logic i_clr_ovr,
  output logic o_pend,
  output logic o_ovr
);

  logic r_s0;
  logic r_s1;
  logic r_s2;
  logic r_pend;
  logic r_ovr;

  logic w_strobe;
  logic w_take;
  logic w_ovr_set;

  assign w_strobe  = r_s1 & ~r_s2;
  assign w_take    = w_strobe & i_en;
  // A strobe landing on the same edge as the grant clear simply re-arms
  // the request; only a strobe onto a still-pending line is an overrun.
  assign w_ovr_set = w_take & r_pend & ~i_clr_pend;

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s0   <= 1'b0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_pend <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_s0 <= i_raw;
      r_s1 <= r_s0;
      r_s2 <= r_s1;

      if (w_take)
        r_pend <= 1'b1;
      else if (i_clr_pend)
        r_pend <= 1'b0;

      // Set has priority over the software clear.
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (i_clr_ovr)
        r_ovr <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_ovr  = r_ovr;

endmodule

// File: rtl/edge_req_arbiter.sv
// edge_req_arbiter
// Captures rising edges on N asynchronous request lines and grants them
// one at a time, round-robin, to a shared service resource. A grant is
// held until the resource acknowledges it. All state updates on the
// falling edge of C.
//
// Ports
//   C          clock (negedge active)
//   RST_N      asynchronous active-low reset
//   I[N]       raw request levels
//   EN[N]      per-line enable
//   REQ_VALID  grant presented
//   REQ_ID     granted line index (meaningful only with REQ_VALID)
//   REQ_ACK    resource consumed the grant
//   PEND[N]    pending-request bitmap
//   OVR[N]     sticky overrun flags
//   CLR_OVR[N] write-one-to-clear for OVR
//
// FSM states
//   state    | meaning
//   ST_IDLE  | no grant out; pick next enabled pending line from r_ptr
//   ST_GRANT | grant r_id held stable until REQ_ACK is sampled
module edge_req_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = IDW_DEF
) (
  input  logic           C,
  input  logic           RST_N,
  input  logic [N-1:0]   I,
  input  logic [N-1:0]   EN,
  output logic           REQ_VALID,
  output logic [IDW-1:0] REQ_ID,
  input  logic           REQ_ACK,
  output logic [N-1:0]   PEND,
  output logic [N-1:0]   OVR,
  input  logic [N-1:0]   CLR_OVR
);

  localparam logic [IDW:0]   L_N   = (IDW+1)'(N);
  localparam logic [IDW-1:0] L_NM1 = IDW'(N-1);

  arb_state_e     r_state;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_ptr;

  logic [N-1:0]   w_clr_pend;
  logic [N-1:0]   w_cand;
  logic [N-1:0]   w_rot;
  logic           w_any;
  logic [IDW-1:0] w_off;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_nxt_ptr;

  for (genvar g = 0; g < N; g++) begin : g_cell
    assign w_clr_pend[g] = (r_state == ST_GRANT) && REQ_ACK && (r_id == IDW'(g));

    edge_capture_cell u_cell (
      .i_clk      (C),
      .i_rst_n    (RST_N),
      .i_raw      (I[g]),
      .i_en       (EN[g]),
      .i_clr_pend (w_clr_pend[g]),
      .i_clr_ovr  (CLR_OVR[g]),
      .o_pend     (PEND[g]),
      .o_ovr      (OVR[g])
    );
  end

  // Round-robin pick: rotate the candidates so r_ptr sits at bit 0, take
  // the lowest set bit, then rotate the offset back modulo N.
  always_comb begin
    w_cand = PEND & EN;
    w_rot  = N'({w_cand, w_cand} >> r_ptr);
    w_any  = |w_rot;
    w_off  = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (w_rot[k])
        w_off = IDW'(k);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= L_N)
      w_sum = w_sum - L_N;
    w_sel = w_sum[IDW-1:0];
  end

  assign w_nxt_ptr = (r_id == L_NM1) ? '0 : r_id + IDW'(1);

  // EN is deliberately not consulted in ST_GRANT: disabling a line does
  // not abort a grant already presented.
  always_ff @(negedge C or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id    <= w_sel;
            r_valid <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (REQ_ACK) begin
            r_ptr   <= w_nxt_ptr;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign REQ_VALID = r_valid;
  assign REQ_ID    = r_id;

endmodule

// File: doc/edge_req_arbiter.md
EDGE_REQ_ARBITER -- requirements
Module: edge_req_arbiter

Interface
REQ-001 The parameter N SHALL default to 4 and set the number of request lines (legal range 2..8).
REQ-002 The parameter IDW SHALL default to 2 and set the width of the grant index; it SHALL satisfy 2**IDW >= N.
REQ-003 Port C SHALL be an input, 1 bit wide: the single clock; all state SHALL update on the negative edge of C.
REQ-004 Port RST_N SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-005 Port I SHALL be an input, N bits wide: raw level request lines, asynchronous to C.
REQ-006 Port EN SHALL be an input, N bits wide: per-line enable; 0 means edges on that line are ignored.
REQ-007 Port REQ_VALID SHALL be an output, 1 bit wide: a grant is presented to the shared service resource.
REQ-008 Port REQ_ID SHALL be an output, IDW bits wide: the index of the granted line; it SHALL be valid only while REQ_VALID=1.
REQ-009 Port REQ_ACK SHALL be an input, 1 bit wide: the resource has consumed the current grant.
REQ-010 Port PEND SHALL be an output, N bits wide: the pending-request bitmap.
REQ-011 Port OVR SHALL be an output, N bits wide: sticky per-line overrun flags.
REQ-012 Port CLR_OVR SHALL be an input, N bits wide: write-one-to-clear for OVR.

Function
REQ-013 Each line SHALL pass through a 3-flop chain (S0<=I, S1<=S0, S2<=S1); the rising-edge strobe SHALL be S1 & ~S2.
REQ-014 A strobe on line i with EN[i]=1 SHALL set PEND[i] on that clock edge, so PEND[i] is visible 3 clocks after I[i] is first sampled high.
REQ-015 A strobe on line i with EN[i]=0 SHALL be discarded, with no PEND or OVR update.
REQ-016 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-017 IDLE: REQ_VALID=0; if any PEND[j] & EN[j] is set, the next edge SHALL latch REQ_ID = the first such j searching upward from pointer PTR (wrapping from N-1 to 0), set REQ_VALID=1, and enter GRANT.
REQ-018 GRANT: REQ_ID and REQ_VALID SHALL stay stable until REQ_ACK=1 is sampled.
REQ-019 On REQ_ACK=1 in GRANT, the FSM SHALL clear PEND[REQ_ID], set PTR=(REQ_ID+1) mod N, drop REQ_VALID, and return to IDLE; back-to-back grants are therefore separated by one IDLE cycle.
REQ-020 REQ_ACK sampled while in IDLE SHALL be ignored.
REQ-021 A strobe on line i while PEND[i]=1 and PEND[i] is not being cleared in the same cycle SHALL set OVR[i]; PEND[i] remains 1.
REQ-022 A strobe on line i in the same cycle that PEND[i] is cleared by ACK SHALL leave PEND[i]=1 and SHALL NOT set OVR[i].
REQ-023 Clearing EN[i] while line i is granted SHALL NOT abort the grant.
REQ-024 Clearing EN[i] while line i is only pending SHALL keep PEND[i] set but exclude line i from selection.
REQ-025 When CLR_OVR[i]=1 and an overrun event on line i occur in the same cycle, the set SHALL win and OVR[i]=1.

Reset
REQ-026 While RST_N=0, all outputs and internal state SHALL be cleared immediately, independent of C: S0/S1/S2=0, PEND=0, OVR=0, REQ_VALID=0, REQ_ID=0, PTR=0, FSM=IDLE.
REQ-027 A reset asserted during GRANT SHALL drop the grant without any ACK and discard all pending requests.
REQ-028 Because the sync chain resets to 0, a line held high through reset release SHALL produce one strobe 2 clocks after release.

Structure
REQ-029 The FSM state encoding and the default values of N/IDW SHALL reside in the shared package edge_arb_pkg.
REQ-030 The per-line sync/strobe/PEND/OVR logic SHALL be one sub-module, edge_capture_cell, instantiated N times.
REQ-031 The round-robin select SHALL be combinational logic in the top level.

Verification
REQ-032 The bench SHALL pulse I[2] high for 5 clocks with EN=4'hF and REQ_ACK tied 1 -> PEND[2] rises 3 clocks after sampling; REQ_VALID=1 with REQ_ID=2 for one clock; PEND returns to 0; OVR=0.
REQ-033 The bench SHALL raise I[0], I[1] and I[3] simultaneously with PTR=0 and ACK given 1 clock after each VALID -> grant order 0,1,3 with one IDLE cycle between grants.
REQ-034 The bench SHALL toggle I[1] twice while line 1 is pending and REQ_ACK is held 0 -> OVR[1]=1 and PEND[1]=1; after CLR_OVR[1]=1 for one clock, OVR[1]=0.
REQ-035 The bench SHALL put an I[3] strobe in the same cycle as an ACK of ID=3 -> PEND[3] remains 1, OVR[3]=0, and a second grant of ID=3 follows.
REQ-036 The bench SHALL drive EN=4'b1101 with strobes on lines 1 and 2 -> line 1 is never pending and only ID=2 is granted.
REQ-037 The bench SHALL pull RST_N low mid-GRANT between clock edges -> REQ_VALID, PEND and OVR go to 0 immediately; after release the FSM is IDLE with PTR=0.
